// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and phase encoding for the VGA sync path.
// Defaults describe 640x480@60 on a 25 MHz pixel clock.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_CW        = 10;

    localparam bit DEF_HS_POL    = 1'b0;
    localparam bit DEF_VS_POL    = 1'b0;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    function automatic int axis_total(input int visible, input int fp,
                                      input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus ACTIVE/FP/SYNC/BP phase decode.
// Used once per line (inc tied high) and once per frame (inc = line wrap).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FP      = DEF_H_FP,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BP      = DEF_H_BP,
    parameter int CW      = DEF_CW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic [1:0]    phase
);

    localparam int TOTAL = axis_total(VISIBLE, FP, SYNC, BP);
    localparam int CWX   = CW + 1;

    // Thresholds are compared one bit wider so a boundary equal to 2^CW still works.
    localparam logic [CW:0]   L_FP_START   = CWX'(VISIBLE);
    localparam logic [CW:0]   L_SYNC_START = CWX'(VISIBLE + FP);
    localparam logic [CW:0]   L_BP_START   = CWX'(VISIBLE + FP + SYNC);
    localparam logic [CW-1:0] L_LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] L_ONE        = CW'(1);

    logic [CW:0] cnt_x;
    phase_t      phase_n;

    assign wrap  = inc && (cnt == L_LAST);
    assign cnt_x = {1'b0, cnt};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + L_ONE;
        end
    end

    // Empty phases fall through because their start and end thresholds coincide.
    always_comb begin
        phase_n = PH_BP;
        if (cnt_x < L_FP_START) begin
            phase_n = PH_ACTIVE;
        end else if (cnt_x < L_SYNC_START) begin
            phase_n = PH_FP;
        end else if (cnt_x < L_BP_START) begin
            phase_n = PH_SYNC;
        end
    end

    assign phase = phase_n;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: sync pulses, visible flag, coordinates and strobes.
// Optional frame counter is built only when VGA_FRAME_COUNT_EN is defined.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HS_POL    = DEF_HS_POL,
    parameter bit VS_POL    = DEF_VS_POL,
    parameter int CW        = DEF_CW
) (
    input  logic          clk,
    input  logic          clr,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] px,
    output logic [CW-1:0] py,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic [1:0]    h_phase;
    logic [1:0]    v_phase;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP),
        .CW      (CW)
    ) u_h_axis (
        .clk   (clk),
        .clr   (clr),
        .inc   (1'b1),
        .cnt   (h_cnt),
        .wrap  (h_wrap),
        .phase (h_phase)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP),
        .CW      (CW)
    ) u_v_axis (
        .clk   (clk),
        .clr   (clr),
        .inc   (h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap),
        .phase (v_phase)
    );

    // Stage p0: flags meaning "counters now sit at column 0 / at (0,0)".
    // Reset parks the counters at (0,0), so both flags come out of reset set.
    logic line_pend_p0;
    logic frame_pend_p0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            line_pend_p0  <= 1'b1;
            frame_pend_p0 <= 1'b1;
        end else begin
            line_pend_p0  <= h_wrap;
            frame_pend_p0 <= h_wrap && v_wrap;
        end
    end

    // Stage p1: registered outputs decoded from the current (hc,vc).
    logic          hsync_p1;
    logic          vsync_p1;
    logic          video_on_p1;
    logic [CW-1:0] px_p1;
    logic [CW-1:0] py_p1;
    logic          line_start_p1;
    logic          frame_start_p1;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hsync_p1       <= ~HS_POL;
            vsync_p1       <= ~VS_POL;
            video_on_p1    <= 1'b0;
            px_p1          <= '0;
            py_p1          <= '0;
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
        end else begin
            hsync_p1       <= (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            vsync_p1       <= (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
            video_on_p1    <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            px_p1          <= h_cnt;
            py_p1          <= v_cnt;
            line_start_p1  <= line_pend_p0;
            frame_start_p1 <= frame_pend_p0;
        end
    end

    assign hsync       = hsync_p1;
    assign vsync       = vsync_p1;
    assign video_on    = video_on_p1;
    assign px          = px_p1;
    assign py          = py_p1;
    assign line_start  = line_start_p1;
    assign frame_start = frame_start_p1;

`ifdef VGA_FRAME_COUNT_EN
    // Advances on the same edge that registers frame_start.
    logic [7:0] frame_cnt_p1;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            frame_cnt_p1 <= 8'd0;
        end else if (frame_pend_p0) begin
            frame_cnt_p1 <= frame_cnt_p1 + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_p1;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a compact-timing instance and a default-timing instance.
module tb_vga_sync_gen;

    localparam int SH_V = 6, SH_F = 0, SH_S = 2, SH_B = 2;
    localparam int SV_V = 3, SV_F = 1, SV_S = 1, SV_B = 1;
    localparam int DH_V = 640, DH_F = 16, DH_S = 96, DH_B = 48;
    localparam int DV_V = 480, DV_F = 10, DV_S = 2, DV_B = 33;
`ifdef VGA_FRAME_COUNT_EN
    localparam int FC_ON = 1;
`else
    localparam int FC_ON = 0;
`endif

    logic clk = 1'b0;
    logic clr_s, clr_d;
    always #20 clk = ~clk;

    logic       s_hsync, s_vsync, s_video, s_ls, s_fs;
    logic [9:0] s_px, s_py;
    logic [7:0] s_fc;
    logic       d_hsync, d_vsync, d_video, d_ls, d_fs;
    logic [9:0] d_px, d_py;
    logic [7:0] d_fc;

    vga_sync_gen #(
        .H_VISIBLE(SH_V), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_VISIBLE(SV_V), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .HS_POL(1'b0), .VS_POL(1'b1), .CW(10)
    ) u_small (
        .clk(clk), .clr(clr_s), .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video),
        .px(s_px), .py(s_py), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
    );

    vga_sync_gen u_dflt (
        .clk(clk), .clr(clr_d), .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video),
        .px(d_px), .py(d_py), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Spec-level model: t is the number of pixel-clock edges since reset release.
    task automatic check_model(input string tag, input int t,
                               input int hv, input int hf, input int hs, input int hb,
                               input int vv, input int vf, input int vs, input int vb,
                               input int hp, input int vp,
                               input int px, input int py, input int hsy, input int vsy,
                               input int von, input int ls, input int fs, input int fc);
        int ht, vt, x, y;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        x  = t % ht;
        y  = (t / ht) % vt;
        check({tag, ".px"}, px, x);
        check({tag, ".py"}, py, y);
        check({tag, ".video_on"}, von, (x < hv && y < vv) ? 1 : 0);
        check({tag, ".hsync"}, hsy, (x >= hv + hf && x < hv + hf + hs) ? hp : 1 - hp);
        check({tag, ".vsync"}, vsy, (y >= vv + vf && y < vv + vf + vs) ? vp : 1 - vp);
        check({tag, ".line_start"}, ls, (x == 0) ? 1 : 0);
        check({tag, ".frame_start"}, fs, (x == 0 && y == 0) ? 1 : 0);
        check({tag, ".frame_cnt"}, fc, FC_ON * (((t / (ht * vt)) + 1) % 256));
    endtask

    task automatic check_reset(input string tag, input int hp, input int vp,
                               input int px, input int py, input int hsy, input int vsy,
                               input int von, input int ls, input int fs, input int fc);
        check({tag, ".rst.px"}, px, 0);
        check({tag, ".rst.py"}, py, 0);
        check({tag, ".rst.video_on"}, von, 0);
        check({tag, ".rst.hsync"}, hsy, 1 - hp);
        check({tag, ".rst.vsync"}, vsy, 1 - vp);
        check({tag, ".rst.line_start"}, ls, 0);
        check({tag, ".rst.frame_start"}, fs, 0);
        check({tag, ".rst.frame_cnt"}, fc, 0);
    endtask

    // Single compare process covering both instances every cycle.
    int ts = 0, td = 0;
    always @(posedge clk) begin
        bit cs, cd;
        int tsn, tdn;
        cs = clr_s;
        cd = clr_d;
        tsn = ts;
        tdn = td;
        ts = cs ? 0 : ts + 1;
        td = cd ? 0 : td + 1;
        #1;
        if (cs) check_reset("s", 0, 1, int'(s_px), int'(s_py), int'(s_hsync), int'(s_vsync),
                            int'(s_video), int'(s_ls), int'(s_fs), int'(s_fc));
        else check_model("s", tsn, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, 0, 1,
                         int'(s_px), int'(s_py), int'(s_hsync), int'(s_vsync),
                         int'(s_video), int'(s_ls), int'(s_fs), int'(s_fc));
        if (cd) check_reset("d", 0, 0, int'(d_px), int'(d_py), int'(d_hsync), int'(d_vsync),
                            int'(d_video), int'(d_ls), int'(d_fs), int'(d_fc));
        else check_model("d", tdn, DH_V, DH_F, DH_S, DH_B, DV_V, DV_F, DV_S, DV_B, 0, 0,
                         int'(d_px), int'(d_py), int'(d_hsync), int'(d_vsync),
                         int'(d_video), int'(d_ls), int'(d_fs), int'(d_fc));
    end

    task automatic wait_s(input int x, input int y, input int lim);
        int n = 0;
        while (!(int'(s_px) == x && int'(s_py) == y) && n < lim) begin
            @(posedge clk); #2; n++;
        end
        check($sformatf("reach_s(%0d,%0d)", x, y), (int'(s_px) == x && int'(s_py) == y) ? 1 : 0, 1);
    endtask

    task automatic wait_d(input int x, input int y, input int lim);
        int n = 0;
        while (!(int'(d_px) == x && int'(d_py) == y) && n < lim) begin
            @(posedge clk); #2; n++;
        end
        check($sformatf("reach_d(%0d,%0d)", x, y), (int'(d_px) == x && int'(d_py) == y) ? 1 : 0, 1);
    endtask

    task automatic small_seq();
        @(posedge clk); #2;
        check("first.px", int'(s_px), 0);
        check("first.py", int'(s_py), 0);
        check("first.video_on", int'(s_video), 1);
        check("first.frame_start", int'(s_fs), 1);
        check("first.line_start", int'(s_ls), 1);
        check("first.hsync", int'(s_hsync), 1);
        check("first.vsync", int'(s_vsync), 0);
        check("first.frame_cnt", int'(s_fc), FC_ON);
        @(posedge clk); #2;
        check("second.px", int'(s_px), 1);
        check("second.frame_start", int'(s_fs), 0);
        wait_s(6, 0, 20);
        check("zero_fp.video_on", int'(s_video), 0);
        check("zero_fp.hsync", int'(s_hsync), 0);
        @(posedge clk); #2;
        check("sync_last.hsync", int'(s_hsync), 0);
        @(posedge clk); #2;
        check("bp_first.hsync", int'(s_hsync), 1);
        wait_s(0, 4, 60);
        check("vsync_row4", int'(s_vsync), 1);
        wait_s(9, 5, 60);
        @(posedge clk); #2;
        check("wrap.px", int'(s_px), 0);
        check("wrap.py", int'(s_py), 0);
        check("wrap.frame_start", int'(s_fs), 1);
        check("wrap.frame_cnt", int'(s_fc), 2 * FC_ON);
        @(posedge clk); #2;
        wait_s(0, 0, 70);
        check("third_fs.frame_cnt", int'(s_fc), 3 * FC_ON);
        repeat (15120) @(posedge clk);
        #2;
        check("fc255.frame_start", int'(s_fs), 1);
        check("fc255.frame_cnt", int'(s_fc), 255 * FC_ON);
        repeat (60) @(posedge clk);
        #2;
        check("fc_wrap.frame_cnt", int'(s_fc), 0);
        wait_s(7, 2, 70);
        @(negedge clk);
        clr_s = 1'b1;
        #1;
        check("async.px", int'(s_px), 0);
        check("async.py", int'(s_py), 0);
        check("async.hsync", int'(s_hsync), 1);
        check("async.vsync", int'(s_vsync), 0);
        check("async.video_on", int'(s_video), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr_s = 1'b0;
        @(posedge clk); #2;
        check("rerelease.px", int'(s_px), 0);
        check("rerelease.py", int'(s_py), 0);
        check("rerelease.frame_start", int'(s_fs), 1);
        check("rerelease.frame_cnt", int'(s_fc), FC_ON);
        repeat (130) @(posedge clk);
    endtask

    task automatic dflt_seq();
        int n, lows;
        @(posedge clk); #2;
        check("d_first.frame_start", int'(d_fs), 1);
        check("d_first.hsync", int'(d_hsync), 1);
        check("d_first.vsync", int'(d_vsync), 1);
        wait_d(640, 0, 700);
        check("d_vis_end.video_on", int'(d_video), 0);
        wait_d(656, 0, 20);
        lows = 0;
        n = 0;
        while (d_hsync == 1'b0 && n < 200) begin
            lows++;
            @(posedge clk); #2; n++;
        end
        check("d_hsync_low_cycles", lows, 96);
        check("d_hsync_rise.px", int'(d_px), 752);
        wait_d(799, 0, 100);
        @(posedge clk); #2;
        check("d_line_wrap.px", int'(d_px), 0);
        check("d_line_wrap.py", int'(d_py), 1);
        check("d_line_wrap.line_start", int'(d_ls), 1);
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (d_ls == 1'b0 && n < 1000);
        check("d_line_period", n, 800);
        wait_d(799, 10, 9000);
        @(posedge clk); #2;
        check("d_row11.px", int'(d_px), 0);
        check("d_row11.py", int'(d_py), 11);
    endtask

    initial begin
        #(40 * 40000);
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        clr_s = 1'b1;
        clr_d = 1'b1;
        repeat (3) @(negedge clk);
        clr_s = 1'b0;
        clr_d = 1'b0;
        fork
            small_seq();
            dflt_seq();
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
